ptr_regfile: RTL and testbench
==============================

Name: ptr_regfile

Overview:
Parametrised pointer register file, successor to the fixed 4 x 12-bit P0–P3 file. It provides N pointer registers of width W, one write port, two combinational read ports and a new post-step port. The step port adds a signed delta to one pointer per cycle with modular wrap, and it reports the wrap in a flag. It sits in the io881 datapath beside the accumulator/byte registers and feeds address generation.

Parameters:
WIDTH, 12, pointer register width in bits (>= 4).
NREGS, 4, number of pointer registers (power of two, >= 2).
DWIDTH, 4, width of signed step delta (<= WIDTH).
BYPASS, 0, 1 = read ports forward same-cycle write data; 0 = read ports show stored value only.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
d  in  WIDTH  write data.
pselw  in  log2(NREGS)  write register select.
wep  in  1  write enable.
psel0  in  log2(NREGS)  read port 0 select.
psel1  in  log2(NREGS)  read port 1 select.
qp0  out  WIDTH  read port 0 data (combinational).
qp1  out  WIDTH  read port 1 data (combinational).
stepsel  in  log2(NREGS)  step register select.
step  in  1  step enable.
delta  in  DWIDTH  signed two's-complement step amount.
wrap  out  1  registered; 1 if last accepted step wrapped.
busy_reg  out  NREGS  registered one-hot: register modified in previous cycle.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: if reset=1 at a rising clk edge, all registers go to 0, wrap=0 and busy_reg=0. Reset overrides wep and step in that cycle. Reset mid-sequence discards any pending step.
- Write: wep=1 at a rising edge sets reg[pselw]=d. The value is visible on qp0/qp1 after the edge (zero-cycle read of stored state).
- Read: qp0=reg[psel0] and qp1=reg[psel1], purely combinational. Both ports may select the same register.
- When BYPASS=1, wep=1 and psel==pselw, the port shows d combinationally before the edge. With BYPASS=0 the port shows the old value.
- Step: step=1 at a rising edge sets reg[stepsel] = (reg[stepsel] + sign_extend(delta)) mod 2^WIDTH.
- wrap is set if the unsigned sum carried out (positive delta) or borrowed (negative delta) across 0/2^WIDTH. Otherwise wrap is cleared.
- wrap holds its value when no step is accepted.
- delta=0 is a legal step: the value is unchanged and wrap=0.
- Write and step on different registers in the same cycle: both take effect.
- Write and step on the same register: the write wins, the step is discarded and wrap=0.
- busy_reg: bit k=1 for exactly one cycle after reg k was written or stepped. More than one bit is set if a write and a step hit different registers.
- Out-of-range selects cannot occur (NREGS is a power of two).
- No read latency. Write and step latency is 1 edge.

Decomposition:
- Shared package io881_pkg holds:
  - localparam PSEL_W = $clog2(NREGS);
  - a function sext_delta(delta) -> WIDTH;
  - a function step_wraps(old, delta) -> 1 bit, for bench reuse.
- One natural sub-module, ptr_stepper: a combinational adder taking old value and delta, returning new value and wrap. It keeps the carry/borrow rule isolated and unit-testable.
- Register array and priority logic stay in ptr_regfile.

Test Plan:
- Reset, then read all N registers on both ports -> every qp0/qp1 = 0x000, wrap=0, busy_reg=0.
- Write 0xAAA, 0x555, then 0x111<<i to each P_i; read all on both ports -> P_i = 0x111<<i, values retained while other registers are written.
- P2=0xFFE, step delta=+3 -> P2=0x001, wrap=1. Step delta=-2 -> P2=0xFFF, wrap=1. Step delta=0 -> P2=0xFFF, wrap=0.
- Same cycle: wep pselw=1 d=0x123, step stepsel=1 delta=+1 -> P1=0x123, wrap=0, busy_reg=0b0010. Repeat with stepsel=3 (P3=0x300) -> P1=0x123, P3=0x301, busy_reg=0b1010.
- BYPASS=1 build: wep=1 pselw=0 d=0x5A5, psel0=0 before the edge -> qp0=0x5A5. BYPASS=0 build, same stimulus -> qp0 = old P0 until after the edge.
- Load P0=0x777, assert reset together with wep (d=0x123) and step -> after the edge P0=0x000, wrap=0. Then step delta=-1 -> P0=0xFFF, wrap=1.

Source files
------------

// File: rtl/io881_pkg.sv
// Shared io881 definitions: default pointer-file geometry and delta helpers.
// The helper functions are fixed to the default geometry.
package io881_pkg;

    localparam int WIDTH_DEF  = 12;
    localparam int NREGS_DEF  = 4;
    localparam int DWIDTH_DEF = 4;
    localparam int PSEL_W     = $clog2(NREGS_DEF);

    function automatic logic [WIDTH_DEF-1:0] sext_delta(input logic [DWIDTH_DEF-1:0] delta);
        return WIDTH_DEF'($signed(delta));
    endfunction

    // A carry out on a negative delta means no borrow, hence the XOR with the sign.
    function automatic logic step_wraps(input logic [WIDTH_DEF-1:0] old,
                                        input logic [DWIDTH_DEF-1:0] delta);
        logic [WIDTH_DEF:0] sum;
        sum = {1'b0, old} + {1'b0, sext_delta(delta)};
        return sum[WIDTH_DEF] ^ delta[DWIDTH_DEF-1];
    endfunction

endpackage

// File: rtl/ptr_regfile_ptr_stepper.sv
// Combinational pointer stepper: old + signed delta modulo 2^WIDTH, with wrap flag.
module ptr_stepper #(
    parameter int WIDTH  = 12,
    parameter int DWIDTH = 4
) (
    input  logic [WIDTH-1:0]  old,
    input  logic [DWIDTH-1:0] delta,
    output logic [WIDTH-1:0]  sum,
    output logic              wrap
);
    import io881_pkg::*;

    logic [WIDTH-1:0] ext;
    logic [WIDTH:0]   full;

    assign ext  = WIDTH'($signed(delta));
    assign full = {1'b0, old} + {1'b0, ext};
    assign sum  = full[WIDTH-1:0];
    // Positive delta wraps on carry out, negative delta wraps when there is no carry (borrow).
    assign wrap = full[WIDTH] ^ delta[DWIDTH-1];

endmodule

// File: rtl/ptr_regfile.sv
// Parametrised pointer register file: one write port, two combinational read
// ports and a post-step port with modular wrap reporting.
module ptr_regfile #(
    parameter int WIDTH  = 12,
    parameter int NREGS  = 4,
    parameter int DWIDTH = 4,
    parameter int BYPASS = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         d,
    input  logic [$clog2(NREGS)-1:0] pselw,
    input  logic                     wep,
    input  logic [$clog2(NREGS)-1:0] psel0,
    input  logic [$clog2(NREGS)-1:0] psel1,
    output logic [WIDTH-1:0]         qp0,
    output logic [WIDTH-1:0]         qp1,
    input  logic [$clog2(NREGS)-1:0] stepsel,
    input  logic                     step,
    input  logic [DWIDTH-1:0]        delta,
    output logic                     wrap,
    output logic [NREGS-1:0]         busy_reg
);
    import io881_pkg::*;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] step_sum;
    logic             step_wrap;
    logic             collide;

    ptr_stepper #(
        .WIDTH  (WIDTH),
        .DWIDTH (DWIDTH)
    ) u_stepper (
        .old   (regs[stepsel]),
        .delta (delta),
        .sum   (step_sum),
        .wrap  (step_wrap)
    );

    assign collide = wep && (pselw == stepsel);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wrap     <= 1'b0;
            busy_reg <= '0;
        end else begin
            busy_reg <= '0;
            // A write to the stepped register wins; the discarded step still clears wrap.
            if (step) begin
                if (collide) begin
                    wrap <= 1'b0;
                end else begin
                    regs[stepsel]     <= step_sum;
                    wrap              <= step_wrap;
                    busy_reg[stepsel] <= 1'b1;
                end
            end
            if (wep) begin
                regs[pselw]     <= d;
                busy_reg[pselw] <= 1'b1;
            end
        end
    end

    always_comb begin
        qp0 = regs[psel0];
        qp1 = regs[psel1];
        if (BYPASS != 0 && wep) begin
            if (psel0 == pselw) qp0 = d;
            if (psel1 == pselw) qp1 = d;
        end
    end

endmodule

// File: tb/tb_ptr_regfile.sv
// Self-checking bench for ptr_regfile: directed vector table, hand sequences
// and randomized traffic against an arithmetic reference model.
module tb_ptr_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] d;
    logic [1:0]  pselw, psel0, psel1, stepsel;
    logic        wep, step;
    logic [3:0]  delta;
    logic [11:0] qp0_a, qp1_a, qp0_b, qp1_b;
    logic        wrap_a, wrap_b;
    logic [3:0]  busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    int mreg [4];
    int mwrap;
    int mbusy;

    always #5 clk = ~clk;

    ptr_regfile #(.WIDTH(12), .NREGS(4), .DWIDTH(4), .BYPASS(0)) dut (
        .clk(clk), .reset(reset), .d(d), .pselw(pselw), .wep(wep),
        .psel0(psel0), .psel1(psel1), .qp0(qp0_a), .qp1(qp1_a),
        .stepsel(stepsel), .step(step), .delta(delta),
        .wrap(wrap_a), .busy_reg(busy_a)
    );

    ptr_regfile #(.WIDTH(12), .NREGS(4), .DWIDTH(4), .BYPASS(1)) dut_bp (
        .clk(clk), .reset(reset), .d(d), .pselw(pselw), .wep(wep),
        .psel0(psel0), .psel1(psel1), .qp0(qp0_b), .qp1(qp1_b),
        .stepsel(stepsel), .step(step), .delta(delta),
        .wrap(wrap_b), .busy_reg(busy_b)
    );

    typedef struct {
        logic        wep;
        logic [1:0]  pselw;
        logic [11:0] d;
        logic        step;
        logic [1:0]  stepsel;
        logic [3:0]  delta;
        logic [1:0]  rsel0;
        logic [1:0]  rsel1;
        logic [11:0] exp0;
        logic [11:0] exp1;
        logic        exp_wrap;
        logic [3:0]  exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] pw, input logic [11:0] dd,
                         input logic s, input logic [1:0] ss, input logic [3:0] dl);
        wep = w; pselw = pw; d = dd; step = s; stepsel = ss; delta = dl;
    endtask

    // Reference model: plain integer arithmetic on the pointer values.
    task automatic tick;
        int nreg [4];
        int nwrap, nbusy, sdelta, s;
        nreg  = mreg;
        nwrap = mwrap;
        nbusy = 0;
        if (reset) begin
            nreg  = '{0, 0, 0, 0};
            nwrap = 0;
        end else begin
            if (step) begin
                if (wep && pselw == stepsel) begin
                    nwrap = 0;
                end else begin
                    sdelta = delta[3] ? int'(delta) - 16 : int'(delta);
                    s = mreg[stepsel] + sdelta;
                    nwrap = (s < 0 || s > 4095) ? 1 : 0;
                    nreg[stepsel] = s & 4095;
                    nbusy = nbusy | (1 << stepsel);
                end
            end
            if (wep) begin
                nreg[pselw] = int'(d);
                nbusy = nbusy | (1 << pselw);
            end
        end
        @(posedge clk);
        #1;
        mreg  = nreg;
        mwrap = nwrap;
        mbusy = nbusy;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'd0, 12'h0, 1'b0, 2'd0, 4'h0);
        psel0 = 2'd0; psel1 = 2'd0;
        mreg = '{0, 0, 0, 0}; mwrap = 0; mbusy = 0;
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            psel0 = 2'(i); psel1 = 2'(3 - i);
            #1;
            chk("reset_qp0", 32'(qp0_a), 32'h0);
            chk("reset_qp1", 32'(qp1_a), 32'h0);
        end
        chk("reset_wrap", 32'(wrap_a), 32'h0);
        chk("reset_busy", 32'(busy_a), 32'h0);

        //           wep pw d       stp ss dl   r0 r1 e0       e1       wr bsy
        vecs.push_back('{1, 0, 12'hAAA, 0, 0, 4'h0, 0, 1, 12'hAAA, 12'h000, 0, 4'b0001});
        vecs.push_back('{1, 1, 12'h555, 0, 0, 4'h0, 0, 1, 12'hAAA, 12'h555, 0, 4'b0010});
        vecs.push_back('{1, 0, 12'h111, 0, 0, 4'h0, 0, 1, 12'h111, 12'h555, 0, 4'b0001});
        vecs.push_back('{1, 1, 12'h222, 0, 0, 4'h0, 1, 0, 12'h222, 12'h111, 0, 4'b0010});
        vecs.push_back('{1, 2, 12'h444, 0, 0, 4'h0, 2, 1, 12'h444, 12'h222, 0, 4'b0100});
        vecs.push_back('{1, 3, 12'h888, 0, 0, 4'h0, 3, 0, 12'h888, 12'h111, 0, 4'b1000});
        vecs.push_back('{0, 0, 12'h000, 0, 0, 4'h0, 2, 2, 12'h444, 12'h444, 0, 4'b0000});
        vecs.push_back('{1, 2, 12'hFFE, 0, 0, 4'h0, 2, 3, 12'hFFE, 12'h888, 0, 4'b0100});
        vecs.push_back('{0, 0, 12'h000, 1, 2, 4'h3, 2, 0, 12'h001, 12'h111, 1, 4'b0100});
        vecs.push_back('{0, 0, 12'h000, 1, 2, 4'hE, 2, 0, 12'hFFF, 12'h111, 1, 4'b0100});
        vecs.push_back('{0, 0, 12'h000, 0, 0, 4'h0, 2, 0, 12'hFFF, 12'h111, 1, 4'b0000});
        vecs.push_back('{0, 0, 12'h000, 1, 2, 4'h0, 2, 0, 12'hFFF, 12'h111, 0, 4'b0100});
        vecs.push_back('{1, 3, 12'h300, 0, 0, 4'h0, 3, 2, 12'h300, 12'hFFF, 0, 4'b1000});
        vecs.push_back('{0, 0, 12'h000, 1, 1, 4'hF, 1, 0, 12'h221, 12'h111, 0, 4'b0010});
        vecs.push_back('{1, 1, 12'h123, 1, 1, 4'h1, 1, 0, 12'h123, 12'h111, 0, 4'b0010});
        vecs.push_back('{1, 1, 12'h123, 1, 3, 4'h1, 1, 3, 12'h123, 12'h301, 0, 4'b1010});

        foreach (vecs[k]) begin
            drive(vecs[k].wep, vecs[k].pselw, vecs[k].d, vecs[k].step, vecs[k].stepsel, vecs[k].delta);
            tick();
            drive(1'b0, 2'd0, 12'h0, 1'b0, 2'd0, 4'h0);
            psel0 = vecs[k].rsel0; psel1 = vecs[k].rsel1;
            #1;
            chk($sformatf("vec%0d_qp0", k), 32'(qp0_a), 32'(vecs[k].exp0));
            chk($sformatf("vec%0d_qp1", k), 32'(qp1_a), 32'(vecs[k].exp1));
            chk($sformatf("vec%0d_wrap", k), 32'(wrap_a), 32'(vecs[k].exp_wrap));
            chk($sformatf("vec%0d_busy", k), 32'(busy_a), 32'(vecs[k].exp_busy));
        end

        // Bypass: same stimulus, only the BYPASS=1 instance forwards d before the edge.
        drive(1'b1, 2'd0, 12'h5A5, 1'b0, 2'd0, 4'h0);
        psel0 = 2'd0; psel1 = 2'd1;
        #1;
        chk("nobypass_qp0_pre", 32'(qp0_a), 32'h111);
        chk("bypass_qp0_pre", 32'(qp0_b), 32'h5A5);
        chk("bypass_qp1_other", 32'(qp1_b), 32'h123);
        tick();
        drive(1'b0, 2'd0, 12'h0, 1'b0, 2'd0, 4'h0);
        #1;
        chk("nobypass_qp0_post", 32'(qp0_a), 32'h5A5);
        chk("bypass_qp0_post", 32'(qp0_b), 32'h5A5);

        // Reset overrides write and step; stepping afterwards starts from zero.
        drive(1'b1, 2'd0, 12'h777, 1'b1, 2'd2, 4'h1);
        tick();
        chk("pre_reset_wrap", 32'(wrap_a), 32'h1);
        reset = 1'b1;
        drive(1'b1, 2'd0, 12'h123, 1'b1, 2'd0, 4'h1);
        tick();
        reset = 1'b0;
        drive(1'b0, 2'd0, 12'h0, 1'b0, 2'd0, 4'h0);
        psel0 = 2'd0; psel1 = 2'd2;
        #1;
        chk("rst_ovr_p0", 32'(qp0_a), 32'h0);
        chk("rst_ovr_p2", 32'(qp1_a), 32'h0);
        chk("rst_ovr_wrap", 32'(wrap_a), 32'h0);
        chk("rst_ovr_busy", 32'(busy_a), 32'h0);
        drive(1'b0, 2'd0, 12'h0, 1'b1, 2'd0, 4'hF);
        tick();
        drive(1'b0, 2'd0, 12'h0, 1'b0, 2'd0, 4'h0);
        #1;
        chk("post_rst_step_p0", 32'(qp0_a), 32'hFFF);
        chk("post_rst_step_wrap", 32'(wrap_a), 32'h1);
        chk("post_rst_step_busy", 32'(busy_a), 32'h1);

        // Randomized traffic; the model has tracked every edge so far.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 12'($urandom),
                  1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 4'($urandom));
            psel0 = 2'($urandom_range(0, 3));
            psel1 = 2'($urandom_range(0, 3));
            #1;
            chk("rnd_qp0", 32'(qp0_a), 32'(mreg[psel0]));
            chk("rnd_qp1", 32'(qp1_a), 32'(mreg[psel1]));
            chk("rnd_bp_qp0", 32'(qp0_b), (wep && psel0 == pselw) ? 32'(d) : 32'(mreg[psel0]));
            chk("rnd_bp_qp1", 32'(qp1_b), (wep && psel1 == pselw) ? 32'(d) : 32'(mreg[psel1]));
            tick();
            chk("rnd_wrap", 32'(wrap_a), 32'(mwrap));
            chk("rnd_busy", 32'(busy_a), 32'(mbusy));
            chk("rnd_bp_wrap", 32'(wrap_b), 32'(mwrap));
            chk("rnd_bp_busy", 32'(busy_b), 32'(mbusy));
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
